// File: rtl/mc_ctrl.sv
// Multi-cycle controller for the RV32I-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB
// over one shared datapath, waits on imem/dmem acks, counts retirements, halts on faults.
module mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic [4:0]       ALUOp,
  output logic [5:0]       EXTOp,
  output logic [2:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       cause
);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT);

  localparam logic [4:0] ALU_NOP = 5'b00000, ALU_LUI = 5'b00001, ALU_ADD = 5'b00011,
                         ALU_SUB = 5'b00100, ALU_XOR = 5'b01100, ALU_OR  = 5'b01101,
                         ALU_AND = 5'b01110, ALU_SLL = 5'b01111, ALU_SRL = 5'b10000,
                         ALU_SRA = 5'b10001, ALU_SLT = 5'b01010, ALU_SLTU = 5'b01011;
  localparam logic [5:0] EXT_SH = 6'b100000, EXT_I = 6'b010000, EXT_S = 6'b001000,
                         EXT_B  = 6'b000100, EXT_U = 6'b000010, EXT_J = 6'b000001;
  localparam logic [2:0] NPC_P4 = 3'b000, NPC_BR = 3'b001, NPC_JMP = 3'b010;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_R, C_IALU, C_LUI, C_LOAD, C_STORE, C_BEQ, C_JAL, C_ILL} cls_t;

  state_t           r_state, w_nstate;
  cls_t             r_cls, w_cls;
  logic [TW-1:0]    r_tcnt, w_tinc;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       r_cause, w_ncause;
  logic             w_wait, w_tmo;
  logic [4:0]       w_c_alu, w_aluop;
  logic             w_c_src, w_alusrc;
  logic [5:0]       w_c_ext, w_extop;
  logic             w_imem_req, w_dmem_req, w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_retire;
  logic [2:0]       w_npcop;
  logic [1:0]       w_wdsel;

  // Instruction class from the IR fields; anything outside the legal set is C_ILL.
  always_comb begin
    w_cls = C_ILL;
    case (Op)
      7'b0110011: if (Funct7 == 7'b0000000 ||
                      (Funct7 == 7'b0100000 && (Funct3 == 3'b000 || Funct3 == 3'b101))) w_cls = C_R;
      7'b0010011: if (Funct3 == 3'b000 || Funct3 == 3'b100 || Funct3 == 3'b110 || Funct3 == 3'b111 ||
                      (Funct3 == 3'b101 && Funct7 == 7'b0000000)) w_cls = C_IALU;
      7'b0110111: w_cls = C_LUI;
      7'b0000011: if (Funct3 == 3'b010) w_cls = C_LOAD;
      7'b0100011: if (Funct3 == 3'b010) w_cls = C_STORE;
      7'b1100011: if (Funct3 == 3'b000) w_cls = C_BEQ;
      7'b1101111: w_cls = C_JAL;
      default: ;
    endcase
  end

  // ALU/immediate controls for the latched class; the IR stays stable so funct fields are live.
  always_comb begin
    w_c_alu = ALU_NOP;
    w_c_src = 1'b0;
    w_c_ext = '0;
    case (r_cls)
      C_R: begin
        case (Funct3)
          3'b000:  w_c_alu = Funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  w_c_alu = ALU_SLL;
          3'b010:  w_c_alu = ALU_SLT;
          3'b011:  w_c_alu = ALU_SLTU;
          3'b100:  w_c_alu = ALU_XOR;
          3'b101:  w_c_alu = Funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  w_c_alu = ALU_OR;
          default: w_c_alu = ALU_AND;
        endcase
      end
      C_IALU: begin
        w_c_src = 1'b1;
        w_c_ext = EXT_I;
        case (Funct3)
          3'b000:  w_c_alu = ALU_ADD;
          3'b100:  w_c_alu = ALU_XOR;
          3'b110:  w_c_alu = ALU_OR;
          3'b111:  w_c_alu = ALU_AND;
          3'b101:  begin w_c_alu = ALU_SRL; w_c_ext = EXT_SH; end
          default: ;
        endcase
      end
      C_LUI:   begin w_c_alu = ALU_LUI; w_c_src = 1'b1; w_c_ext = EXT_U; end
      C_LOAD:  begin w_c_alu = ALU_ADD; w_c_src = 1'b1; w_c_ext = EXT_I; end
      C_STORE: begin w_c_alu = ALU_ADD; w_c_src = 1'b1; w_c_ext = EXT_S; end
      C_BEQ:   begin w_c_alu = ALU_SUB; w_c_ext = EXT_B; end
      C_JAL:   w_c_ext = EXT_J;
      default: ;
    endcase
  end

  assign w_tinc = r_tcnt + TW'(1);
  assign w_wait = (r_state == S_FETCH && !imem_ack) || (r_state == S_MEM && !dmem_ack);
  assign w_tmo  = (MEM_TIMEOUT != 0) && w_wait && (w_tinc == TLIM);

  always_comb begin
    w_nstate   = r_state;
    w_ncause   = r_cause;
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_retire   = 1'b0;
    w_aluop    = ALU_NOP;
    w_alusrc   = 1'b0;
    w_extop    = '0;
    w_npcop    = NPC_P4;
    w_wdsel    = WD_ALU;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_irwrite = 1'b1;
          w_nstate  = S_DECODE;
        end else if (w_tmo) begin
          w_nstate = S_HALT;
          w_ncause = 2'b10;
        end
      end
      S_DECODE: begin
        if (w_cls == C_ILL) begin
          w_nstate = S_HALT;
          w_ncause = 2'b01;
        end else begin
          w_nstate = S_EXEC;
        end
      end
      S_EXEC: begin
        w_aluop  = w_c_alu;
        w_alusrc = w_c_src;
        w_extop  = w_c_ext;
        if (r_cls == C_BEQ) begin
          w_pcwrite = 1'b1;
          w_npcop   = Zero ? NPC_BR : NPC_P4;
          w_retire  = 1'b1;
          w_nstate  = S_FETCH;
        end else if (r_cls == C_LOAD || r_cls == C_STORE) begin
          w_nstate = S_MEM;
        end else begin
          w_nstate = S_WB;
        end
      end
      S_MEM: begin
        w_aluop    = w_c_alu;
        w_alusrc   = w_c_src;
        w_extop    = w_c_ext;
        w_dmem_req = 1'b1;
        w_memwrite = (r_cls == C_STORE);
        if (dmem_ack) begin
          if (r_cls == C_STORE) begin
            w_pcwrite = 1'b1;
            w_retire  = 1'b1;
            w_nstate  = S_FETCH;
          end else begin
            w_nstate = S_WB;
          end
        end else if (w_tmo) begin
          w_nstate = S_HALT;
          w_ncause = 2'b10;
        end
      end
      S_WB: begin
        w_aluop    = w_c_alu;
        w_alusrc   = w_c_src;
        w_extop    = w_c_ext;
        w_regwrite = 1'b1;
        w_pcwrite  = 1'b1;
        w_retire   = 1'b1;
        w_wdsel    = (r_cls == C_LOAD) ? WD_MEM : (r_cls == C_JAL) ? WD_PC : WD_ALU;
        w_npcop    = (r_cls == C_JAL) ? NPC_JMP : NPC_P4;
        w_nstate   = S_FETCH;
      end
      S_HALT: ;
      default: w_nstate = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_FETCH;
      r_cls     <= C_ILL;
      r_tcnt    <= '0;
      r_instret <= '0;
      r_cause   <= 2'b00;
    end else begin
      r_state <= w_nstate;
      r_cause <= w_ncause;
      r_tcnt  <= (w_wait && !w_tmo) ? w_tinc : '0;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Everything is held low while reset is asserted so no partial write can escape.
  assign imem_req = rstn & w_imem_req;
  assign dmem_req = rstn & w_dmem_req;
  assign IRWrite  = rstn & w_irwrite;
  assign PCWrite  = rstn & w_pcwrite;
  assign RegWrite = rstn & w_regwrite;
  assign MemWrite = rstn & w_memwrite;
  assign ALUSrc   = rstn & w_alusrc;
  assign retire   = rstn & w_retire;
  assign halted   = rstn & (r_state == S_HALT);
  assign ALUOp    = rstn ? w_aluop   : '0;
  assign EXTOp    = rstn ? w_extop   : '0;
  assign NPCOp    = rstn ? w_npcop   : '0;
  assign WDSel    = rstn ? w_wdsel   : '0;
  assign instret  = rstn ? r_instret : '0;
  assign cause    = rstn ? r_cause   : '0;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction into its expected
// per-cycle output trace; a compare process checks the DUT against it every cycle.
module tb_mc_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_LUI = 3'd2, K_LD = 3'd3, K_ST = 3'd4,
                         K_BEQ = 3'd5, K_JAL = 3'd6;

  typedef struct packed {
    logic imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc;
    logic [4:0] ALUOp;
    logic [5:0] EXTOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic retire, halted;
    logic [1:0] cause;
  } ov_t;
  typedef struct packed { ov_t o; logic ia; logic da; } step_t;
  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic uf3; logic uf7;
    logic [2:0] k; logic [4:0] alu; logic src; logic [5:0] ext;
  } ins_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic [6:0] Op = '0, Funct7 = '0;
  logic [2:0] Funct3 = '0;
  logic Zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc, retire, halted;
  logic [4:0] ALUOp;
  logic [5:0] EXTOp;
  logic [2:0] NPCOp;
  logic [1:0] WDSel, cause;
  logic [CW-1:0] instret;

  mc_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp), .NPCOp(NPCOp), .WDSel(WDSel),
    .retire(retire), .instret(instret), .halted(halted), .cause(cause)
  );

  always #5 clk = ~clk;

  ov_t got, exp_o = '0;
  logic [CW-1:0] m_cnt = '0;
  int nvec = 0, nerr = 0;
  bit chk_en = 0;
  string tname = "reset";
  step_t seq[$];
  ins_t tbl[20];

  assign got = {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc,
                ALUOp, EXTOp, NPCOp, WDSel, retire, halted, cause};

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (!rstn) m_cnt = '0;
      nvec++;
      if (got !== exp_o) begin
        nerr++;
        $display("FAIL %s outputs: got %h expected %h", tname, got, exp_o);
      end
      nvec++;
      if (instret !== m_cnt) begin
        nerr++;
        $display("FAIL %s instret: got %0d expected %0d", tname, instret, m_cnt);
      end
      if (rstn && exp_o.retire) m_cnt = m_cnt + 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, g, e);
    end
  endtask

  function automatic ins_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic uf3, input logic uf7, input logic [2:0] k,
                              input logic [4:0] alu, input logic src, input logic [5:0] ext);
    ins_t e;
    e = '{op, f3, f7, uf3, uf7, k, alu, src, ext};
    return e;
  endfunction

  task automatic init_tbl();
    tbl[0]  = mk(7'b0110011, 3'b000, 7'h00, 1, 1, K_R,   5'b00011, 0, 6'b000000); // add
    tbl[1]  = mk(7'b0110011, 3'b000, 7'h20, 1, 1, K_R,   5'b00100, 0, 6'b000000); // sub
    tbl[2]  = mk(7'b0110011, 3'b001, 7'h00, 1, 1, K_R,   5'b01111, 0, 6'b000000); // sll
    tbl[3]  = mk(7'b0110011, 3'b010, 7'h00, 1, 1, K_R,   5'b01010, 0, 6'b000000); // slt
    tbl[4]  = mk(7'b0110011, 3'b011, 7'h00, 1, 1, K_R,   5'b01011, 0, 6'b000000); // sltu
    tbl[5]  = mk(7'b0110011, 3'b100, 7'h00, 1, 1, K_R,   5'b01100, 0, 6'b000000); // xor
    tbl[6]  = mk(7'b0110011, 3'b101, 7'h00, 1, 1, K_R,   5'b10000, 0, 6'b000000); // srl
    tbl[7]  = mk(7'b0110011, 3'b101, 7'h20, 1, 1, K_R,   5'b10001, 0, 6'b000000); // sra
    tbl[8]  = mk(7'b0110011, 3'b110, 7'h00, 1, 1, K_R,   5'b01101, 0, 6'b000000); // or
    tbl[9]  = mk(7'b0110011, 3'b111, 7'h00, 1, 1, K_R,   5'b01110, 0, 6'b000000); // and
    tbl[10] = mk(7'b0010011, 3'b000, 7'h00, 1, 0, K_I,   5'b00011, 1, 6'b010000); // addi
    tbl[11] = mk(7'b0010011, 3'b100, 7'h00, 1, 0, K_I,   5'b01100, 1, 6'b010000); // xori
    tbl[12] = mk(7'b0010011, 3'b110, 7'h00, 1, 0, K_I,   5'b01101, 1, 6'b010000); // ori
    tbl[13] = mk(7'b0010011, 3'b111, 7'h00, 1, 0, K_I,   5'b01110, 1, 6'b010000); // andi
    tbl[14] = mk(7'b0010011, 3'b101, 7'h00, 1, 1, K_I,   5'b10000, 1, 6'b100000); // srli
    tbl[15] = mk(7'b0110111, 3'b000, 7'h00, 0, 0, K_LUI, 5'b00001, 1, 6'b000010); // lui
    tbl[16] = mk(7'b0000011, 3'b010, 7'h00, 1, 0, K_LD,  5'b00011, 1, 6'b010000); // lw
    tbl[17] = mk(7'b0100011, 3'b010, 7'h00, 1, 0, K_ST,  5'b00011, 1, 6'b001000); // sw
    tbl[18] = mk(7'b1100011, 3'b000, 7'h00, 1, 0, K_BEQ, 5'b00100, 0, 6'b000100); // beq
    tbl[19] = mk(7'b1101111, 3'b000, 7'h00, 0, 0, K_JAL, 5'b00000, 0, 6'b000001); // jal
  endtask

  function automatic void lookup(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                 output bit lg, output ins_t e);
    lg = 0;
    e  = '0;
    foreach (tbl[i])
      if (tbl[i].op == op && (!tbl[i].uf3 || tbl[i].f3 == f3) && (!tbl[i].uf7 || tbl[i].f7 == f7)) begin
        lg = 1;
        e  = tbl[i];
      end
  endfunction

  task automatic push(input ov_t o, input logic ia, input logic da);
    step_t s;
    s.o = o; s.ia = ia; s.da = da;
    seq.push_back(s);
  endtask

  task automatic halt_fill(input logic [1:0] c, input int n, input logic st);
    ov_t o;
    for (int i = 0; i < n; i++) begin
      o = '0; o.halted = 1'b1; o.cause = c;
      push(o, st, st);
    end
  endtask

  // Expands one instruction into its cycle trace; iw/dw are wait cycles, negative = never ack.
  task automatic build(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic z, input int iw, input int dw, input logic st, input int hc);
    ins_t e; bit lg; ov_t a, o; int n;
    seq.delete();
    Op = op; Funct7 = f7; Funct3 = f3; Zero = z;
    lookup(op, f7, f3, lg, e);
    a = '0; a.ALUOp = e.alu; a.ALUSrc = e.src; a.EXTOp = e.ext;
    n = (iw < 0) ? TO : iw;
    for (int i = 0; i < n; i++) begin o = '0; o.imem_req = 1'b1; push(o, 1'b0, st); end
    if (iw < 0) begin halt_fill(2'b10, hc, st); return; end
    o = '0; o.imem_req = 1'b1; o.IRWrite = 1'b1; push(o, 1'b1, 1'b0);
    push('0, st, st);
    if (!lg) begin halt_fill(2'b01, hc, st); return; end
    o = a;
    if (e.k == K_BEQ) begin
      o.PCWrite = 1'b1; o.NPCOp = z ? 3'b001 : 3'b000; o.retire = 1'b1;
      push(o, st, st);
      return;
    end
    push(o, st, st);
    if (e.k == K_LD || e.k == K_ST) begin
      n = (dw < 0) ? TO : dw;
      for (int i = 0; i < n; i++) begin
        o = a; o.dmem_req = 1'b1; o.MemWrite = (e.k == K_ST); push(o, st, 1'b0);
      end
      if (dw < 0) begin halt_fill(2'b10, hc, st); return; end
      o = a; o.dmem_req = 1'b1; o.MemWrite = (e.k == K_ST);
      if (e.k == K_ST) begin
        o.PCWrite = 1'b1; o.retire = 1'b1;
        push(o, 1'b0, 1'b1);
        return;
      end
      push(o, 1'b0, 1'b1);
    end
    o = a; o.RegWrite = 1'b1; o.PCWrite = 1'b1; o.retire = 1'b1;
    o.WDSel = (e.k == K_LD) ? 2'b01 : (e.k == K_JAL) ? 2'b10 : 2'b00;
    o.NPCOp = (e.k == K_JAL) ? 3'b010 : 3'b000;
    push(o, st, st);
  endtask

  task automatic run_seq();
    foreach (seq[i]) begin
      imem_ack = seq[i].ia; dmem_ack = seq[i].da; exp_o = seq[i].o;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; exp_o = '0; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rstn = 1'b1;
  endtask

  logic [6:0] ill_op[9] = '{7'b1111111, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011,
                            7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
  logic [6:0] ill_f7[9] = '{7'h00, 7'h00, 7'h20, 7'h01, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [2:0] ill_f3[9] = '{3'b000, 3'b001, 3'b101, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b010};

  initial begin
    logic [6:0] f7;
    logic [2:0] f3;
    init_tbl();
    @(posedge clk); #1;
    chk_en = 1;
    do_reset(2);

    tname = "add";
    build(7'b0110011, 7'h00, 3'b000, 0, 0, 0, 0, 0);
    chk("add_len", seq.size(), 4);
    chk("add_exec_aluop", seq[2].o.ALUOp, 5'b00011);
    chk("add_wb_regwrite", seq[3].o.RegWrite, 1);
    run_seq();
    chk("add_instret", instret, 1);

    tname = "lw";
    build(7'b0000011, 7'h00, 3'b010, 0, 0, 3, 0, 0);
    chk("lw_len", seq.size(), 8);
    chk("lw_wb_wdsel", seq[7].o.WDSel, 2'b01);
    chk("lw_wb_extop", seq[7].o.EXTOp, 6'b010000);
    run_seq();

    tname = "beq_taken";
    build(7'b1100011, 7'h00, 3'b000, 1, 0, 0, 0, 0);
    chk("beq1_len", seq.size(), 3);
    chk("beq1_npcop", seq[2].o.NPCOp, 3'b001);
    run_seq();
    tname = "beq_not_taken";
    build(7'b1100011, 7'h00, 3'b000, 0, 0, 0, 0, 0);
    chk("beq0_npcop", seq[2].o.NPCOp, 3'b000);
    run_seq();

    tname = "jal";
    build(7'b1101111, 7'h00, 3'b000, 0, 0, 0, 0, 0);
    chk("jal_wb", {seq[3].o.RegWrite, seq[3].o.WDSel, seq[3].o.NPCOp, seq[3].o.EXTOp},
        {1'b1, 2'b10, 3'b010, 6'b000001});
    run_seq();
    chk("instret_5", instret, 5);

    // Every legal instruction, varied wait states up to the timeout boundary, stray acks.
    for (int i = 0; i < 20; i++) begin
      tname = $sformatf("legal_%0d", i);
      f7 = tbl[i].uf7 ? tbl[i].f7 : 7'($urandom);
      f3 = tbl[i].uf3 ? tbl[i].f3 : 3'($urandom);
      build(tbl[i].op, f7, f3, 1'(i % 2), (i + 1) % 4, i % 4, 1, 0);
      run_seq();
    end
    chk("instret_wrap", instret, 9);

    for (int j = 0; j < 9; j++) begin
      tname = $sformatf("illegal_%0d", j);
      build(ill_op[j], ill_f7[j], ill_f3[j], 0, 0, 0, 1, (j == 0) ? 20 : 3);
      run_seq();
      chk("ill_cause", {halted, cause}, 3'b101);
      chk("ill_instret", instret, (j == 0) ? 9 : 0);
      do_reset(1);
    end

    tname = "imem_timeout";
    build(7'b0110011, 7'h00, 3'b000, 0, -1, 0, 1, 5);
    chk("itmo_len", seq.size(), 9);
    chk("itmo_halt", {seq[4].o.halted, seq[4].o.cause}, 3'b110);
    run_seq();
    chk("itmo_cause", cause, 2'b10);
    do_reset(1);

    tname = "dmem_timeout";
    build(7'b0100011, 7'h00, 3'b010, 0, 0, -1, 1, 3);
    run_seq();
    chk("dtmo_cause", cause, 2'b10);
    do_reset(1);

    tname = "sw_reset_in_mem";
    build(7'b0100011, 7'h00, 3'b010, 0, 0, 1, 0, 0);
    void'(seq.pop_back());
    run_seq();
    do_reset(1);
    tname = "add_after_reset";
    build(7'b0110011, 7'h00, 3'b000, 0, 0, 0, 0, 0);
    run_seq();
    chk("post_reset_instret", instret, 1);

    tname = "beq_wrap";
    do_reset(1);
    for (int k = 0; k < 17; k++) begin
      build(7'b1100011, 7'h00, 3'b000, 1'(k % 2), 0, 0, 1'(k % 2), 0);
      run_seq();
    end
    chk("beq_wrap_instret", instret, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
